// File: rtl/ad_scan_pkg.sv
// Shared types and defaults for the analog front-end scan sequencer.
//   state_e    : sequencer FSM states
//   ch_pick_t  : result of a priority search over the latched channel mask
//   pick_from  : lowest set mask bit at or above a starting index
`timescale 1ns/1ps
package ad_scan_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCnv,
    StConv,
    StShift,
    StStore
  } state_e;

  localparam int unsigned DefDataW      = 16;
  localparam int unsigned DefNch        = 8;
  localparam int unsigned DefSclkHalf   = 4;
  localparam int unsigned DefSettleCyc  = 50;
  localparam int unsigned DefCnvLowCyc  = 2;
  localparam int unsigned DefConvCyc    = 100;

  // Channel index is 3 bits wide, so the mux never has more than 8 inputs.
  localparam int unsigned NchMax = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } ch_pick_t;

  function automatic ch_pick_t pick_from(input logic [NchMax-1:0] mask,
                                         input logic [3:0]        from);
    ch_pick_t pick;
    pick = '0;
    // Walk downwards so the lowest qualifying bit is the last one written.
    for (int i = NchMax - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) begin
        pick.found = 1'b1;
        pick.idx   = 3'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ad_spi_rx.sv
// SCLK generator and MSB-first shift register for the serial SAR ADC.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset, aborts any transfer
//   go_i    : one-cycle start; SCLK is high on the following cycle
//   sdout_i : raw ADC serial data (synchronised here)
//   sclk_o  : ADC serial clock, idles low
//   done_o  : high on the last cycle of the transfer
//   data_o  : received word
`timescale 1ns/1ps
module ad_spi_rx #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SCLK_HALF = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic              sdout_i,
  output logic              sclk_o,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned HalfW = $clog2(SCLK_HALF + 1);
  localparam int unsigned BitW  = $clog2(DATA_W + 1);

  logic [1:0]        sync_q;
  logic              active_q, active_d;
  logic              sclk_q, sclk_d;
  logic [HalfW-1:0]  half_q, half_d;
  logic [BitW-1:0]   bits_q, bits_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  always_comb begin
    active_d = active_q;
    sclk_d   = sclk_q;
    half_d   = half_q;
    bits_d   = bits_q;
    shreg_d  = shreg_q;
    done_o   = active_q & ~sclk_q & (half_q == '0) & (bits_q == '0);
    if (go_i) begin
      active_d = 1'b1;
      sclk_d   = 1'b1;
      half_d   = HalfW'(SCLK_HALF - 1);
      bits_d   = BitW'(DATA_W);
    end else if (active_q) begin
      if (half_q != '0) begin
        half_d = half_q - HalfW'(1);
      end else if (sclk_q) begin
        // Falling edge: capture the synchronised bit.
        sclk_d  = 1'b0;
        half_d  = HalfW'(SCLK_HALF - 1);
        bits_d  = bits_q - BitW'(1);
        shreg_d = {shreg_q[DATA_W-2:0], sync_q[1]};
      end else if (bits_q != '0) begin
        sclk_d = 1'b1;
        half_d = HalfW'(SCLK_HALF - 1);
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      half_q   <= '0;
      bits_q   <= '0;
      shreg_q  <= '0;
    end else begin
      sync_q   <= {sync_q[0], sdout_i};
      active_q <= active_d;
      sclk_q   <= sclk_d;
      half_q   <= half_d;
      bits_q   <= bits_d;
      shreg_q  <= shreg_d;
    end
  end

  assign sclk_o = sclk_q;
  assign data_o = shreg_q;

endmodule

// File: rtl/ad_scan_ctrl.sv
// Scan sequencer for the 8-input analog front end: selects each enabled mux channel,
// waits for settling, pulses conversion start, shifts the result in and reports it.
//   CLK_100M, rst          : clock, synchronous active-high reset
//   scan_en, scan_start    : continuous / single scan triggers
//   ch_mask                : channels to include, latched at scan start
//   ad_sclk, ad_cnvst_n,
//   ad_sdout, ad_sel       : ADC and mux pins
//   smp_valid/ch/data      : per-channel result strobe
//   scan_done, busy        : scan status
`timescale 1ns/1ps
module ad_scan_ctrl
  import ad_scan_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned NCH         = DefNch,
  parameter int unsigned SCLK_HALF   = DefSclkHalf,
  parameter int unsigned SETTLE_CYC  = DefSettleCyc,
  parameter int unsigned CNV_LOW_CYC = DefCnvLowCyc,
  parameter int unsigned CONV_CYC    = DefConvCyc
) (
  input  logic              CLK_100M,
  input  logic              rst,
  input  logic              scan_en,
  input  logic              scan_start,
  input  logic [NCH-1:0]    ch_mask,
  output logic              ad_sclk,
  output logic              ad_cnvst_n,
  input  logic              ad_sdout,
  output logic [NCH-1:0]    ad_sel,
  output logic              smp_valid,
  output logic [2:0]        smp_ch,
  output logic [DATA_W-1:0] smp_data,
  output logic              scan_done,
  output logic              busy
);

  localparam int unsigned MaxCyc =
    (SETTLE_CYC > CONV_CYC) ?
      ((SETTLE_CYC > CNV_LOW_CYC) ? SETTLE_CYC : CNV_LOW_CYC) :
      ((CONV_CYC > CNV_LOW_CYC) ? CONV_CYC : CNV_LOW_CYC);
  localparam int unsigned CntW = $clog2(MaxCyc + 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NchMax-1:0]   mask_q, mask_d, mask_in;
  logic [NCH-1:0]      sel_q, sel_d;
  logic [2:0]          idx_q, idx_d;
  logic                cnvst_n_q, busy_q, done_q, valid_q;
  logic [2:0]          smp_ch_q;
  logic [DATA_W-1:0]   smp_data_q;
  logic                spi_go, spi_done;
  logic [DATA_W-1:0]   spi_data;
  ch_pick_t            first_pick, next_pick;

  always_comb begin
    mask_in = '0;
    mask_in[NCH-1:0] = ch_mask;
  end

  assign first_pick = pick_from(mask_in, 4'd0);
  assign next_pick  = pick_from(mask_q, {1'b0, idx_q} + 4'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    spi_go  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((scan_en || scan_start) && first_pick.found) begin
          mask_d = mask_in;
          idx_d  = first_pick.idx;
          sel_d  = '0;
          sel_d[first_pick.idx] = 1'b1;
          cnt_d   = CntW'(SETTLE_CYC - 1);
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          cnt_d   = CntW'(CNV_LOW_CYC - 1);
          state_d = StCnv;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCnv: begin
        if (cnt_q == '0) begin
          cnt_d   = CntW'(CONV_CYC - 1);
          state_d = StConv;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StConv: begin
        if (cnt_q == '0) begin
          // Start SCLK now so its first high cycle is the first SHIFT cycle.
          spi_go  = 1'b1;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StShift: begin
        if (spi_done) state_d = StStore;
      end
      StStore: begin
        if (next_pick.found) begin
          idx_d  = next_pick.idx;
          sel_d  = '0;
          sel_d[next_pick.idx] = 1'b1;
          cnt_d   = CntW'(SETTLE_CYC - 1);
          state_d = StSettle;
        end else begin
          sel_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_100M) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mask_q     <= '0;
      sel_q      <= '0;
      idx_q      <= '0;
      cnvst_n_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      smp_ch_q   <= '0;
      smp_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      // Pin-facing strobes are registered from the next state so they align with it.
      cnvst_n_q <= (state_d != StCnv);
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_q == StStore) && (state_d == StIdle);
      valid_q   <= (state_d == StStore);
      if (state_d == StStore) begin
        smp_ch_q   <= idx_q;
        smp_data_q <= spi_data;
      end
    end
  end

  ad_spi_rx #(
    .DATA_W    (DATA_W),
    .SCLK_HALF (SCLK_HALF)
  ) u_spi_rx (
    .clk_i   (CLK_100M),
    .rst_i   (rst),
    .go_i    (spi_go),
    .sdout_i (ad_sdout),
    .sclk_o  (ad_sclk),
    .done_o  (spi_done),
    .data_o  (spi_data)
  );

  assign ad_cnvst_n = cnvst_n_q;
  assign ad_sel     = sel_q;
  assign smp_valid  = valid_q;
  assign smp_ch     = smp_ch_q;
  assign smp_data   = smp_data_q;
  assign scan_done  = done_q;
  assign busy       = busy_q;

endmodule

// File: doc/ad_scan_ctrl.md
Name: ad_scan_ctrl

Overview:
- Sequencer for the 8-input analog front end: a serial SAR ADC (AD_CNVST_N / AD_SCLK / AD_SDOUT) behind an 8-way mux (AD_SEL0..7).
- Steps through enabled mux channels, waits for mux settling, starts a conversion, then shifts the result in MSB-first.
- Presents each result as a one-cycle valid strobe with its channel tag.
- Instantiated under top_app and drives the AD_* pins directly.

Parameters:
DATA_W, 16, ADC result width in bits
NCH, 8, number of mux channels; AD_SEL width
SCLK_HALF, 4, CLK_100M cycles per SCLK half-period (minimum 2)
SETTLE_CYC, 50, cycles from mux change to conversion start (minimum 1)
CNV_LOW_CYC, 2, cycles AD_CNVST_N is held low
CONV_CYC, 100, cycles from AD_CNVST_N rising to first SCLK

Ports:
CLK_100M  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
scan_en  in  1  continuous scan; a new scan starts whenever idle and this is high
scan_start  in  1  single-cycle pulse; starts one scan if idle
ch_mask  in  NCH  1 = channel included; sampled once at scan start
ad_sclk  out  1  ADC serial clock, idles low
ad_cnvst_n  out  1  conversion start, active-low
ad_sdout  in  1  ADC serial data
ad_sel  out  NCH  one-hot mux select; all zero when idle
smp_valid  out  1  one-cycle strobe; a new sample is present
smp_ch  out  3  channel index of the sample
smp_data  out  DATA_W  sample value, unsigned
scan_done  out  1  one-cycle pulse after the last enabled channel's sample
busy  out  1  high from scan start until scan_done

Behaviour:
- Clock and reset: one clock, CLK_100M. Reset rst is synchronous and active-high.
- Reset values: ad_sclk=0, ad_cnvst_n=1, ad_sel=0, smp_valid=0, smp_ch=0, smp_data=0, scan_done=0, busy=0, FSM=IDLE.
- Reset asserted mid-conversion or mid-shift aborts the operation; pins return to reset values on the next edge. No partial sample is emitted.
- ad_sdout is registered through two flops before use. The shift register samples the synchronised bit on the clock edge that drives ad_sclk from 1 to 0, so SCLK_HALF ≥ 2 covers synchroniser delay.
- FSM states: IDLE, SETTLE, CNV, CONV, SHIFT, STORE.
- IDLE:
  - Scan trigger is (scan_en | scan_start) with ch_mask ≠ 0.
  - On trigger: latch mask; pick the lowest set bit; drive ad_sel one-hot; busy=1; go to SETTLE.
  - A trigger with mask = 0 is ignored: no busy, no scan_done.
- SETTLE: count SETTLE_CYC cycles, then go to CNV.
- CNV: ad_cnvst_n=0 for CNV_LOW_CYC cycles, then ad_cnvst_n=1; go to CONV.
- CONV: wait CONV_CYC cycles, then go to SHIFT.
- SHIFT:
  - Generate DATA_W SCLK periods, each with SCLK_HALF cycles high then SCLK_HALF low.
  - The first rising edge occurs on the first SHIFT cycle.
  - Shift MSB-first; ad_sclk ends low.
- STORE (1 cycle):
  - smp_valid=1; smp_ch = current index; smp_data = shift register.
  - smp_data holds its value until the next STORE.
- After STORE:
  - If a higher latched mask bit exists: update ad_sel to it and go to SETTLE.
  - Otherwise: scan_done=1 for one cycle, busy=0, ad_sel=0, go to IDLE.
- Scan-to-scan spacing:
  - With scan_en held high, the next scan starts one cycle after scan_done (IDLE lasts exactly 1 cycle).
  - A new ch_mask is picked up at that point.
- Trigger rules:
  - scan_start while busy is ignored; it is not queued.
  - Deasserting scan_en mid-scan lets the current scan complete.
  - ch_mask changes mid-scan have no effect.
- Per-channel latency: SETTLE_CYC + CNV_LOW_CYC + CONV_CYC + 2·SCLK_HALF·DATA_W + 1 cycles. With defaults: 50+2+100+128+1 = 281.
- Counters: one shared down-counter (width covers the maximum of all parameters), a bit counter of width clog2(DATA_W+1), and a 3-bit channel index.

Decomposition:
- Package ad_scan_pkg:
  - FSM state enum (IDLE..STORE).
  - Default timing constants.
  - Function for the lowest set bit at or above an index (priority select over the latched mask).
- One natural sub-module: ad_spi_rx, the SCLK generator plus DATA_W shift register.
  - Inputs: go.
  - Outputs: done, data.
  - It owns the SHIFT timing.
- Sequencing and the mux remain in ad_scan_ctrl.

Test Plan:
1. ADC model returns 16'hA5C3 + ch for every channel; pulse scan_start with ch_mask=8'hFF. Expect 8 smp_valid strobes, smp_ch 0..7 with data A5C3..A5CA, 281 cycles apart, ad_sel one-hot 01..80, then one scan_done pulse; busy drops the same cycle.
2. ch_mask=8'b1000_0101, single scan. Expect samples only on ch 0, 2, 7 in that order; ad_sel never shows 02, 08, 10, 20, 40.
3. scan_en held high with mask 8'h03. Expect back-to-back scans with IDLE lasting exactly 1 cycle between scan_done and the next busy; change the mask to 8'h10 mid-scan, and the next scan samples ch 4 only.
4. Assert rst during SHIFT after 7 bits. Next edge: ad_sclk=0, ad_cnvst_n=1, ad_sel=0, busy=0; no smp_valid ever emitted for the aborted channel.
5. Pulse scan_start while busy, and pulse scan_start with ch_mask=0 while idle. Expect both ignored: no extra samples, no scan_done, busy stays low in the second case.
6. Timing check on one conversion: ad_cnvst_n low for exactly 2 cycles; 100 cycles to the first ad_sclk rise; 16 SCLK periods of 8 cycles; ad_sclk idle low outside SHIFT.
